axi4_master_bridge: RTL

Parametrised AXI4 master that converts a single-outstanding 32-bit word request port, the kind driven by a VProc node, into full AXI4 single-beat transactions on a data bus of configurable width. It supersedes the fixed 32-bit AXI wrapper:
- adds byte strobes, lane steering onto 32–256-bit buses, IDs and response checking;
- adds an explicit handshake state machine;
- optionally adds a watchdog timeout.

It sits between the VProc memory-mapped port and the AXI interconnect.

---
 rtl/axi4_master_bridge.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/axi4_master_bridge.sv
// Single-outstanding 32-bit request port to AXI4 single-beat master with lane steering.
// Optional watchdog enabled by defining AXI4_MASTER_TIMEOUT_EN (limit set by TIMEOUT).
module axi4_master_bridge #(
  parameter int                 ADDRWIDTH = 32,
  parameter int                 DATAWIDTH = 64,
  parameter int                 IDWIDTH   = 4,
  parameter logic [IDWIDTH-1:0] ID        = '0,
  parameter int                 TIMEOUT   = 1024
) (
  input  logic                   clk,
  input  logic                   nreset,
  input  logic [ADDRWIDTH-1:0]   req_addr,
  input  logic [31:0]            req_wdata,
  input  logic [3:0]             req_be,
  input  logic                   req_we,
  input  logic                   req_rd,
  output logic                   req_ack,
  output logic [31:0]            req_rdata,
  output logic                   req_err,
  output logic [IDWIDTH-1:0]     awid,
  output logic [ADDRWIDTH-1:0]   awaddr,
  output logic [7:0]             awlen,
  output logic [2:0]             awsize,
  output logic [1:0]             awburst,
  output logic [2:0]             awprot,
  output logic                   awvalid,
  input  logic                   awready,
  output logic [DATAWIDTH-1:0]   wdata,
  output logic [DATAWIDTH/8-1:0] wstrb,
  output logic                   wlast,
  output logic                   wvalid,
  input  logic                   wready,
  input  logic [IDWIDTH-1:0]     bid,
  input  logic [1:0]             bresp,
  input  logic                   bvalid,
  output logic                   bready,
  output logic [IDWIDTH-1:0]     arid,
  output logic [ADDRWIDTH-1:0]   araddr,
  output logic [7:0]             arlen,
  output logic [2:0]             arsize,
  output logic [1:0]             arburst,
  output logic [2:0]             arprot,
  output logic                   arvalid,
  input  logic                   arready,
  input  logic [IDWIDTH-1:0]     rid,
  input  logic [DATAWIDTH-1:0]   rdata,
  input  logic [1:0]             rresp,
  input  logic                   rlast,
  input  logic                   rvalid,
  output logic                   rready,
  output logic [2:0]             dbg_state
);

  localparam int NLANE = DATAWIDTH / 32;
  localparam int LANEW = (NLANE > 1) ? $clog2(NLANE) : 1;
  localparam int STRBW = DATAWIDTH / 8;

  // Handshake rule on every channel: a transfer happens on the edge where valid and
  // ready are both high; valid and its payload are held unchanged until then.
  typedef enum logic [2:0] {IDLE, WRITE, WRESP, RADDR, RDATA, DONE} state_e;

  state_e               state, state_n;
  logic [LANEW-1:0]     lane, lane_n, lane_in;
  logic [ADDRWIDTH-1:0] addr_al, awaddr_n, araddr_n;
  logic [DATAWIDTH-1:0] wdata_n;
  logic [STRBW-1:0]     wstrb_n;
  logic [31:0]          rword, rdata_n;
  logic                 awvalid_n, wvalid_n, arvalid_n, bready_n, rready_n, ack_n, err_n;
  logic                 unused_addr;

  assign awid      = ID;
  assign arid      = ID;
  assign awlen     = 8'd0;
  assign arlen     = 8'd0;
  assign awsize    = 3'b010;
  assign arsize    = 3'b010;
  assign awburst   = 2'b01;
  assign arburst   = 2'b01;
  assign awprot    = 3'b000;
  assign arprot    = 3'b000;
  assign wlast     = wvalid;
  assign dbg_state = state;

  assign addr_al     = {req_addr[ADDRWIDTH-1:2], 2'b00};
  assign lane_in     = LANEW'(req_addr[ADDRWIDTH-1:2]) & LANEW'(NLANE - 1);
  assign rword       = 32'(rdata >> {lane, 5'b00000});
  assign unused_addr = ^req_addr[1:0];

`ifdef AXI4_MASTER_TIMEOUT_EN
  logic [31:0] cnt;
  always_ff @(posedge clk) begin
    if (!nreset || state == IDLE) cnt <= '0;
    else if (state != DONE)       cnt <= cnt + 32'd1;
  end
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT);
`endif

  always_comb begin
    state_n   = state;
    lane_n    = lane;
    awaddr_n  = awaddr;
    araddr_n  = araddr;
    wdata_n   = wdata;
    wstrb_n   = wstrb;
    awvalid_n = awvalid;
    wvalid_n  = wvalid;
    arvalid_n = arvalid;
    bready_n  = bready;
    rready_n  = rready;
    ack_n     = 1'b0;
    err_n     = req_err;
    rdata_n   = req_rdata;
    case (state)
      IDLE: begin
        if (req_we) begin
          state_n   = WRITE;
          awvalid_n = 1'b1;
          wvalid_n  = 1'b1;
          awaddr_n  = addr_al;
          wdata_n   = {NLANE{req_wdata}};
          wstrb_n   = STRBW'(req_be) << {lane_in, 2'b00};
          lane_n    = lane_in;
        end else if (req_rd) begin
          state_n   = RADDR;
          arvalid_n = 1'b1;
          araddr_n  = addr_al;
          lane_n    = lane_in;
        end
      end
      WRITE: begin
        if (awready) awvalid_n = 1'b0;
        if (wready)  wvalid_n  = 1'b0;
        // AW and W may complete in either order; move on once both are done.
        if ((!awvalid || awready) && (!wvalid || wready)) begin
          state_n  = WRESP;
          bready_n = 1'b1;
        end
      end
      WRESP: begin
        if (bvalid) begin
          state_n  = DONE;
          bready_n = 1'b0;
          ack_n    = 1'b1;
          err_n    = bresp[1] | (bid != ID);
        end
      end
      RADDR: begin
        if (arready) begin
          state_n   = RDATA;
          arvalid_n = 1'b0;
          rready_n  = 1'b1;
        end
      end
      RDATA: begin
        if (rvalid) begin
          state_n  = DONE;
          rready_n = 1'b0;
          ack_n    = 1'b1;
          rdata_n  = rword;
          err_n    = rresp[1] | (rid != ID) | ~rlast;
        end
      end
      default: state_n = IDLE;
    endcase
`ifdef AXI4_MASTER_TIMEOUT_EN
    if (state != IDLE && state != DONE && cnt == 32'(TIMEOUT - 1)) begin
      state_n   = DONE;
      awvalid_n = 1'b0;
      wvalid_n  = 1'b0;
      arvalid_n = 1'b0;
      bready_n  = 1'b0;
      rready_n  = 1'b0;
      ack_n     = 1'b1;
      err_n     = 1'b1;
      rdata_n   = 32'hFFFF_FFFF;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state     <= IDLE;
      lane      <= '0;
      awaddr    <= '0;
      araddr    <= '0;
      wdata     <= '0;
      wstrb     <= '0;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      arvalid   <= 1'b0;
      bready    <= 1'b0;
      rready    <= 1'b0;
      req_ack   <= 1'b0;
      req_err   <= 1'b0;
      req_rdata <= '0;
    end else begin
      state     <= state_n;
      lane      <= lane_n;
      awaddr    <= awaddr_n;
      araddr    <= araddr_n;
      wdata     <= wdata_n;
      wstrb     <= wstrb_n;
      awvalid   <= awvalid_n;
      wvalid    <= wvalid_n;
      arvalid   <= arvalid_n;
      bready    <= bready_n;
      rready    <= rready_n;
      req_ack   <= ack_n;
      req_err   <= err_n;
      req_rdata <= rdata_n;
    end
  end

endmodule
